multi_net_snapshot: RTL and testbench
=====================================

Name: multi_net_snapshot

Overview:
Parametrised multi-channel net capture block. It accepts a packed bus of NUM_CH channels, each CH_WIDTH bits, plus a per-channel emit mask through a valid/ready handshake, and buffers up to DEPTH snapshots. It then serialises the masked channels of each snapshot one per beat on a narrow valid/ready output. It sits between wide parallel net groups (packed and unpacked arrays flattened to a bus) and narrow downstream consumers, and exposes its FSM state as an enum-typed output.

Parameters:
- NUM_CH, 4, number of channels per snapshot (>=1).
- CH_WIDTH, 8, bits per channel (>=1).
- DEPTH, 4, snapshot buffer entries (power of 2, >=2).
- CW = max(1, $clog2(NUM_CH)), derived localparam, channel-index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  snapshot offered.
- in_ready  out  1  buffer can accept a snapshot.
- in_data  in  NUM_CH*CH_WIDTH  channel c occupies bits [c*CH_WIDTH +: CH_WIDTH].
- in_mask  in  NUM_CH  bit c=1: emit channel c.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts beat.
- out_data  out  CH_WIDTH  channel payload.
- out_ch  out  CW  index of the emitted channel.
- out_last  out  1  final beat of the current snapshot.
- state  out  1  enum state_t {IDLE=0, EMIT=1}.
- count  out  $clog2(DEPTH)+1  stored snapshots, including the one being emitted.
- overflow  out  1  sticky; in_valid was seen while in_ready=0.

Behaviour:
- Reset (asynchronous, active-high): buffer empty, count=0, state=IDLE, out_valid=0, out_data=0, out_ch=0, out_last=0, overflow=0, in_ready=1. Clearing happens immediately on rst assertion, including mid-snapshot; partially emitted snapshots are lost.
- in_ready = (count < DEPTH). It is registered-derived and independent of out_ready; there is no same-cycle push-through when full.
- Push: on in_valid && in_ready, {in_data, in_mask} is written at the write pointer and count increments. Exception: if in_mask == 0, the handshake completes but nothing is stored and count is unchanged.
- Overflow: if in_valid && !in_ready, overflow is set and stays set until rst. The offered data is not stored.
- FSM:
  - IDLE: out_valid=0. If count>0, go to EMIT and load the channel index with the lowest set mask bit of the head entry.
  - EMIT: out_valid=1. out_data = head.data[idx], out_ch = idx, out_last = 1 when no higher mask bit is set.
  - EMIT, on out_valid && out_ready && !out_last: advance idx to the next set mask bit in ascending order.
  - EMIT, on out_valid && out_ready && out_last: pop the head and decrement count. If the remaining count > 0, stay in EMIT and load the lowest set bit of the new head in the same edge (back-to-back snapshots, no bubble). Otherwise go to IDLE.
- Output holds: out_data, out_ch and out_last stay stable while out_valid && !out_ready.
- Latency: a snapshot accepted at edge t produces out_valid at t+1 from IDLE (one-cycle IDLE->EMIT transition, data is registered).
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- count never exceeds DEPTH.
- When NUM_CH=1, out_ch is 1 bit and always 0.

Test Plan (NUM_CH=4, CH_WIDTH=8, DEPTH=4):
- Reset then push in_data=32'hDDCCBBAA, in_mask=4'b1111, out_ready=1 -> beats AA/ch0, BB/ch1, CC/ch2, DD/ch3 on consecutive cycles, out_last only with DD, count 1->0, state returns to IDLE.
- Push mask 4'b1010 with data 32'h44332211 -> exactly two beats, 22/ch1 then 44/ch3(last). Push mask 4'b0000 -> handshake accepted, no beats, count stays 0.
- out_ready=0 and push 5 snapshots -> count=4, in_ready=0 after the 4th, the 5th sets overflow=1. Raise out_ready -> first 4 snapshots drain in order, overflow remains 1.
- Toggle out_ready 1/0 every cycle during a 4-beat snapshot -> out_data/out_ch stable on stalled cycles, no beat duplicated or skipped.
- Continuous push and drain with masks 4'b0001 each cycle -> count stays constant, pointers wrap past entry 3 with data order preserved over 20 snapshots.
- Assert rst for one cycle after the 2nd beat of a 4-beat snapshot with 2 queued -> immediate out_valid=0, count=0, state=IDLE, overflow=0, in_ready=1. A new push afterwards emits normally.

Source files
------------

// File: rtl/multi_net_snapshot.sv
// Multi-channel snapshot buffer: queues masked channel groups and emits the
// selected channels one per beat on a narrow valid/ready stream.
package multi_net_snapshot_pkg;
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;
endpackage

module multi_net_snapshot
  import multi_net_snapshot_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_WIDTH = 8,
  parameter int unsigned DEPTH    = 4,
  localparam int unsigned CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*CH_WIDTH-1:0]   in_data,
  input  logic [NUM_CH-1:0]            in_mask,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH_WIDTH-1:0]          out_data,
  output logic [CW-1:0]                out_ch,
  output logic                         out_last,
  output state_t                       state,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow
);

  localparam int unsigned DW   = NUM_CH * CH_WIDTH;
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;

  logic [DW-1:0]     data_mem [DEPTH];
  logic [NUM_CH-1:0] mask_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  state_t            state_d;
  logic              push;
  logic              pop;
  logic [CNTW-1:0]   count_d;
  logic              out_valid_d;
  logic [CH_WIDTH-1:0] out_data_d;
  logic [CW-1:0]     out_ch_d;
  logic              out_last_d;
  logic [DW-1:0]     head_data;
  logic [NUM_CH-1:0] head_mask;
  logic [DW-1:0]     nxt_data;
  logic [NUM_CH-1:0] nxt_mask;
  logic [CW-1:0]     sel_ch;

  // Lowest set mask bit at or above 'from'.
  function automatic logic [CW-1:0] first_set(input logic [NUM_CH-1:0] m, input int from);
    logic found;
    first_set = '0;
    found     = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!found && m[i] && (i >= from)) begin
        first_set = CW'(i);
        found     = 1'b1;
      end
    end
  endfunction

  function automatic logic above_set(input logic [NUM_CH-1:0] m, input int pos);
    above_set = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (m[i] && (i > pos)) above_set = 1'b1;
    end
  endfunction

  function automatic logic [CH_WIDTH-1:0] chan(input logic [DW-1:0] d, input logic [CW-1:0] c);
    chan = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (CW'(i) == c) chan = d[i*CH_WIDTH +: CH_WIDTH];
    end
  endfunction

  assign push = in_valid && in_ready && (in_mask != '0);

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    pop        = 1'b0;
    out_data_d = out_data;
    out_ch_d   = out_ch;
    out_last_d = out_last;
    sel_ch     = '0;
    head_data  = data_mem[rd_ptr];
    head_mask  = mask_mem[rd_ptr];
    // With one entry left, the entry following the head is the one being pushed now.
    if (count == CNTW'(1)) begin
      nxt_data = in_data;
      nxt_mask = in_mask;
    end else begin
      nxt_data = data_mem[rd_ptr + PW'(1)];
      nxt_mask = mask_mem[rd_ptr + PW'(1)];
    end

    case (state)
      IDLE: begin
        if (count != '0) begin
          state_d    = EMIT;
          sel_ch     = first_set(head_mask, 0);
          out_ch_d   = sel_ch;
          out_data_d = chan(head_data, sel_ch);
          out_last_d = !above_set(head_mask, int'(sel_ch));
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (!out_last) begin
            sel_ch     = first_set(head_mask, int'(out_ch) + 1);
            out_ch_d   = sel_ch;
            out_data_d = chan(head_data, sel_ch);
            out_last_d = !above_set(head_mask, int'(sel_ch));
          end else begin
            pop = 1'b1;
            if ((count > CNTW'(1)) || push) begin
              sel_ch     = first_set(nxt_mask, 0);
              out_ch_d   = sel_ch;
              out_data_d = chan(nxt_data, sel_ch);
              out_last_d = !above_set(nxt_mask, int'(sel_ch));
            end else begin
              state_d    = IDLE;
              out_ch_d   = '0;
              out_data_d = '0;
              out_last_d = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == EMIT);
    count_d     = count + CNTW'(push) - CNTW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      in_ready  <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      state     <= state_d;
      count     <= count_d;
      wr_ptr    <= wr_ptr + PW'(push);
      rd_ptr    <= rd_ptr + PW'(pop);
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_ch    <= out_ch_d;
      out_last  <= out_last_d;
      in_ready  <= (count_d < CNTW'(DEPTH));
      overflow  <= overflow | (in_valid & ~in_ready);
    end
  end

  // Snapshot storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= in_data;
      mask_mem[wr_ptr] <= in_mask;
    end
  end

endmodule

// File: tb/tb_multi_net_snapshot.sv
// Directed self-checking bench for multi_net_snapshot (4 channels x 8 bits, depth 4).
module tb_multi_net_snapshot;
  import multi_net_snapshot_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_mask;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_last;
  state_t      state;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  multi_net_snapshot #(.NUM_CH(4), .CH_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .state(state), .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [7:0] d, input logic [1:0] c, input logic l);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_ch"},    32'(out_ch),    32'(c));
    chk({tag, "_last"},  32'(out_last),  32'(l));
    step();
  endtask

  logic [7:0] exp4 [4];
  int k;
  int rcv;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;

    // Full-mask snapshot
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_mask = 4'b1111;
    step();
    in_valid = 1'b0;
    chk("t1_count1", 32'(count), 32'd1);
    chk("t1_lat_valid0", 32'(out_valid), 32'd0);
    step();
    beat("t1_b0", 8'hAA, 2'd0, 1'b0);
    beat("t1_b1", 8'hBB, 2'd1, 1'b0);
    beat("t1_b2", 8'hCC, 2'd2, 1'b0);
    chk("t1_count_last", 32'(count), 32'd1);
    beat("t1_b3", 8'hDD, 2'd3, 1'b1);
    chk("t1_done_valid", 32'(out_valid), 32'd0);
    chk("t1_done_count", 32'(count), 32'd0);
    chk("t1_done_state", 32'(state), 32'(IDLE));

    // Sparse mask, then empty mask
    in_valid = 1'b1; in_data = 32'h44332211; in_mask = 4'b1010;
    step();
    in_valid = 1'b0;
    step();
    beat("t2_b0", 8'h22, 2'd1, 1'b0);
    beat("t2_b1", 8'h44, 2'd3, 1'b1);
    chk("t2_done_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_data = 32'h99999999; in_mask = 4'b0000;
    chk("t2_zero_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("t2_zero_count", 32'(count), 32'd0);
    step();
    chk("t2_zero_valid", 32'(out_valid), 32'd0);
    chk("t2_zero_state", 32'(state), 32'(IDLE));

    // Fill while stalled, then overflow
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = {24'h0, 8'(8'h11 + i)}; in_mask = 4'b0001;
      step();
      if (i == 3) begin
        chk("t3_full_count", 32'(count), 32'd4);
        chk("t3_full_ready", 32'(in_ready), 32'd0);
        chk("t3_full_ovf0", 32'(overflow), 32'd0);
      end
    end
    in_valid = 1'b0;
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_ovf_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    beat("t3_d0", 8'h11, 2'd0, 1'b1);
    beat("t3_d1", 8'h12, 2'd0, 1'b1);
    beat("t3_d2", 8'h13, 2'd0, 1'b1);
    beat("t3_d3", 8'h14, 2'd0, 1'b1);
    chk("t3_drain_valid", 32'(out_valid), 32'd0);
    chk("t3_drain_count", 32'(count), 32'd0);
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);

    // Backpressure toggling
    exp4[0] = 8'h21; exp4[1] = 8'h43; exp4[2] = 8'h65; exp4[3] = 8'h87;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h87654321; in_mask = 4'b1111;
    step();
    in_valid = 1'b0;
    step();
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      chk("t4_valid", 32'(out_valid), 32'd1);
      chk("t4_data", 32'(out_data), 32'(exp4[k]));
      chk("t4_ch", 32'(out_ch), 32'(k));
      chk("t4_last", 32'(out_last), 32'(k == 3));
      out_ready = c[0];
      step();
      if (out_ready) k++;
    end
    chk("t4_beats", 32'(k), 32'd4);
    chk("t4_done_valid", 32'(out_valid), 32'd0);

    // Streaming push/drain with pointer wrap
    out_ready = 1'b1; in_valid = 1'b1; in_mask = 4'b0001; in_data = {24'h0, 8'h40};
    rcv = 0;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (out_valid) begin
        chk("t5_data", 32'(out_data), 32'(8'(8'h40 + rcv)));
        rcv++;
      end
      if (e >= 2 && e <= 20) chk("t5_count", 32'(count), 32'd2);
      if (e < 20) in_data = {24'h0, 8'(8'h40 + e)};
      else in_valid = 1'b0;
    end
    chk("t5_rcv", 32'(rcv), 32'd20);
    chk("t5_end_count", 32'(count), 32'd0);

    // Reset mid-snapshot
    out_ready = 1'b0; in_mask = 4'b1111; in_valid = 1'b1;
    in_data = 32'hA3A2A1A0; step();
    in_data = 32'hB3B2B1B0; step();
    in_data = 32'hC3C2C1C0; step();
    in_valid = 1'b0;
    chk("t6_count3", 32'(count), 32'd3);
    out_ready = 1'b1;
    beat("t6_b0", 8'hA0, 2'd0, 1'b0);
    beat("t6_b1", 8'hA1, 2'd1, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_state", 32'(state), 32'(IDLE));
    chk("t6_rst_ovf", 32'(overflow), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 32'h00550000; in_mask = 4'b0100;
    step();
    in_valid = 1'b0;
    step();
    beat("t6_new", 8'h55, 2'd2, 1'b1);
    chk("t6_new_done", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
